// File: rtl/msc_rw_sequencer_if.sv
// rtl/msc_rw_sequencer_if.sv - mapper-side request/status bus of msc_rw_sequencer
interface msc_rw_sequencer_if #(
    parameter int MAX_LUNS = 4
);
    logic                    map_ready;
    logic                    map_read_req;
    logic                    map_write_req;
    logic [2:0]              map_lun;
    logic [31:0]             map_lba;
    logic [15:0]             map_count;
    logic                    map_done;
    logic                    map_error;
    logic [MAX_LUNS-1:0]     lun_present;
    logic [MAX_LUNS-1:0]     lun_readonly;
    logic [32*MAX_LUNS-1:0]  lun_capacity_flat;

    modport master (
        input  map_ready, map_done, map_error, lun_present, lun_readonly, lun_capacity_flat,
        output map_read_req, map_write_req, map_lun, map_lba, map_count
    );

    modport slave (
        output map_ready, map_done, map_error, lun_present, lun_readonly, lun_capacity_flat,
        input  map_read_req, map_write_req, map_lun, map_lba, map_count
    );
endinterface

// File: rtl/msc_rw_sequencer.sv
// rtl/msc_rw_sequencer.sv - READ(10)/WRITE(10) validator and chunk sequencer feeding the LUN mapper
// Optional mapper watchdog enabled by defining MSC_RW_TIMEOUT_EN.
module msc_rw_sequencer #(
    parameter int MAX_LUNS       = 4,
    parameter int CHUNK_SECTORS  = 16,
    parameter int TIMEOUT_CYCLES = 2**24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_is_write,
    input  logic [2:0]  cmd_lun,
    input  logic [31:0] cmd_lba,
    input  logic [15:0] cmd_blocks,
    output logic        rsp_valid,
    output logic        rsp_status,
    output logic [3:0]  rsp_sense_key,
    output logic [7:0]  rsp_asc,
    output logic [15:0] rsp_residue,
    output logic        seq_busy,
    msc_rw_sequencer_if.master map_if
);

    localparam int          LW         = (MAX_LUNS > 1) ? $clog2(MAX_LUNS) : 1;
    localparam logic [3:0]  MAX_LUNS_W = 4'(MAX_LUNS);
    localparam logic [15:0] CHUNK_W    = 16'(CHUNK_SECTORS);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t      state;
    logic        is_write_q;
    logic [2:0]  lun_q;
    logic [31:0] cur_lba;
    logic [15:0] blocks_q;
    logic [15:0] remaining;
    logic        pend_status;
    logic [3:0]  pend_key;
    logic [7:0]  pend_asc;
    logic [15:0] pend_residue;

    logic [LW-1:0] lun_idx;
    logic [31:0]   lun_cap;
    logic [32:0]   end_sum;
    logic          lun_bad;
    logic [15:0]   chunk;
    logic          req_on;

    assign lun_idx = lun_q[LW-1:0];
    assign lun_cap = map_if.lun_capacity_flat[32*lun_idx +: 32];
    assign end_sum = {1'b0, cur_lba} + {17'b0, blocks_q};
    assign lun_bad = ({1'b0, lun_q} >= MAX_LUNS_W);
    assign chunk   = (remaining > CHUNK_W) ? CHUNK_W : remaining;
    assign req_on  = map_if.map_read_req | map_if.map_write_req;

`ifdef MSC_RW_TIMEOUT_EN
    localparam int          TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] wait_cnt;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= S_IDLE;
            cmd_ready            <= 1'b1;
            seq_busy             <= 1'b0;
            rsp_valid            <= 1'b0;
            rsp_status           <= 1'b0;
            rsp_sense_key        <= 4'h0;
            rsp_asc              <= 8'h00;
            rsp_residue          <= 16'h0;
            map_if.map_read_req  <= 1'b0;
            map_if.map_write_req <= 1'b0;
            map_if.map_lun       <= 3'd0;
            map_if.map_lba       <= 32'h0;
            map_if.map_count     <= 16'h0;
            is_write_q           <= 1'b0;
            lun_q                <= 3'd0;
            cur_lba              <= 32'h0;
            blocks_q             <= 16'h0;
            remaining            <= 16'h0;
            pend_status          <= 1'b0;
            pend_key             <= 4'h0;
            pend_asc             <= 8'h00;
            pend_residue         <= 16'h0;
`ifdef MSC_RW_TIMEOUT_EN
            wait_cnt             <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        is_write_q <= cmd_is_write;
                        lun_q      <= cmd_lun;
                        cur_lba    <= cmd_lba;
                        blocks_q   <= cmd_blocks;
                        cmd_ready  <= 1'b0;
                        seq_busy   <= 1'b1;
                        state      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    remaining    <= blocks_q;
                    pend_status  <= 1'b1;
                    pend_residue <= blocks_q;
                    state        <= S_RESP;
                    if (lun_bad) begin
                        pend_key <= 4'h5;
                        pend_asc <= 8'h25;
                    end else if (!map_if.lun_present[lun_idx]) begin
                        pend_key <= 4'h2;
                        pend_asc <= 8'h3A;
                    end else if (is_write_q && map_if.lun_readonly[lun_idx]) begin
                        pend_key <= 4'h7;
                        pend_asc <= 8'h27;
                    end else if (end_sum > {1'b0, lun_cap}) begin
                        pend_key <= 4'h5;
                        pend_asc <= 8'h21;
                    end else if (blocks_q == 16'h0) begin
                        pend_status  <= 1'b0;
                        pend_key     <= 4'h0;
                        pend_asc     <= 8'h00;
                        pend_residue <= 16'h0;
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Request stays up through the mapper's routing cycle, i.e. until ready is seen low.
                    if (!req_on) begin
                        if (map_if.map_ready) begin
                            map_if.map_lun       <= lun_q;
                            map_if.map_lba       <= cur_lba;
                            map_if.map_count     <= chunk;
                            map_if.map_read_req  <= !is_write_q;
                            map_if.map_write_req <= is_write_q;
`ifdef MSC_RW_TIMEOUT_EN
                            wait_cnt             <= '0;
`endif
                        end
                    end else if (!map_if.map_ready) begin
                        map_if.map_read_req  <= 1'b0;
                        map_if.map_write_req <= 1'b0;
                        state                <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (map_if.map_done) begin
                        cur_lba   <= cur_lba + 32'(chunk);
                        remaining <= remaining - chunk;
                        if (remaining == chunk) begin
                            pend_status  <= 1'b0;
                            pend_key     <= 4'h0;
                            pend_asc     <= 8'h00;
                            pend_residue <= 16'h0;
                            state        <= S_RESP;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end else if (map_if.map_error) begin
                        pend_status  <= 1'b1;
                        pend_key     <= 4'h3;
                        pend_asc     <= is_write_q ? 8'h0C : 8'h11;
                        pend_residue <= remaining;
                        state        <= S_RESP;
`ifdef MSC_RW_TIMEOUT_EN
                    end else if (wait_cnt == TLIM) begin
                        pend_status  <= 1'b1;
                        pend_key     <= 4'h4;
                        pend_asc     <= 8'h44;
                        pend_residue <= remaining;
                        state        <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    rsp_valid     <= 1'b1;
                    rsp_status    <= pend_status;
                    rsp_sense_key <= pend_key;
                    rsp_asc       <= pend_asc;
                    rsp_residue   <= pend_residue;
                    cmd_ready     <= 1'b1;
                    seq_busy      <= 1'b0;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
